// File: rtl/demux_sequencial_if.sv
// Bus bundle for the two-channel sequential demux: shared input word, mode and
// button controls, and the two registered output channels with their strobes.
interface demux_sequencial_if #(
  parameter int DATABUS_WIDTH = 9
);
  logic [DATABUS_WIDTH-1:0] dataIn;
  logic                     inValid;
  logic                     toggleButton;
  logic                     autoMode;
  logic [DATABUS_WIDTH-1:0] dataOut1;
  logic [DATABUS_WIDTH-1:0] dataOut2;
  logic                     valid1;
  logic                     valid2;
  logic                     focus;

  modport master (
    output dataIn, inValid, toggleButton, autoMode,
    input  dataOut1, dataOut2, valid1, valid2, focus
  );

  modport slave (
    input  dataIn, inValid, toggleButton, autoMode,
    output dataOut1, dataOut2, valid1, valid2, focus
  );
endinterface

// File: rtl/demux_sequencial.sv
// Routes each valid input word to one of two registered channels. Focus either
// alternates per word (auto mode) or flips on a debounced push-button press.
//
//   state  | meaning
//   FOCUS1 | words are captured into dataOut1 / valid1
//   FOCUS2 | words are captured into dataOut2 / valid2
module demux_sequencial #(
  parameter int DATABUS_WIDTH   = 9,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic                clk,
  input logic                rst,
  demux_sequencial_if.slave  bus
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    FOCUS1 = 1'b0,
    FOCUS2 = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [DATABUS_WIDTH-1:0] dout1_q, dout1_d;
  logic [DATABUS_WIDTH-1:0] dout2_q, dout2_d;
  logic                     valid1_q, valid1_d;
  logic                     valid2_q, valid2_d;

  logic                     sync1_q, sync2_q;
  logic                     deb_q, deb_d;
  logic                     deb_dly_q;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     pulse_q, pulse_d;

  // Button conditioning: 2-flop synchronizer, then a level debouncer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
    end else begin
      sync1_q   <= bus.toggleButton;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      cnt_q     <= cnt_d;
      pulse_q   <= pulse_d;
    end
  end

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Registered rising-edge detect: one pulse per accepted press, none on release.
  assign pulse_d = deb_q & ~deb_dly_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FOCUS1;
      dout1_q  <= '0;
      dout2_q  <= '0;
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dout1_q  <= dout1_d;
      dout2_q  <= dout2_d;
      valid1_q <= valid1_d;
      valid2_q <= valid2_d;
    end
  end

  always_comb begin
    logic flip;
    state_d  = state_q;
    dout1_d  = dout1_q;
    dout2_d  = dout2_q;
    valid1_d = 1'b0;
    valid2_d = 1'b0;
    flip     = bus.autoMode ? bus.inValid : pulse_q;
    // Capture always uses the pre-flip focus.
    case (state_q)
      FOCUS1: begin
        if (bus.inValid) begin
          dout1_d  = bus.dataIn;
          valid1_d = 1'b1;
        end
        state_d = flip ? FOCUS2 : FOCUS1;
      end
      FOCUS2: begin
        if (bus.inValid) begin
          dout2_d  = bus.dataIn;
          valid2_d = 1'b1;
        end
        state_d = flip ? FOCUS1 : FOCUS2;
      end
      default: state_d = FOCUS1;
    endcase
  end

  assign bus.dataOut1 = dout1_q;
  assign bus.dataOut2 = dout2_q;
  assign bus.valid1   = valid1_q;
  assign bus.valid2   = valid2_q;
  assign bus.focus    = (state_q == FOCUS2);

endmodule

// File: tb/tb_demux_sequencial.sv
// Directed bench for demux_sequencial: auto alternation, button debounce
// timing, glitch rejection, coincident capture/flip and asynchronous reset.
module tb_demux_sequencial;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  demux_sequencial_if #(.DATABUS_WIDTH(9)) bus ();

  demux_sequencial #(.DATABUS_WIDTH(9), .DEBOUNCE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [8:0] d1, input logic [8:0] d2,
                            input logic v1, input logic v2, input logic f);
    check({tag, ".dataOut1"}, 16'(bus.dataOut1), 16'(d1));
    check({tag, ".dataOut2"}, 16'(bus.dataOut2), 16'(d2));
    check({tag, ".valid1"},   16'(bus.valid1),   16'(v1));
    check({tag, ".valid2"},   16'(bus.valid2),   16'(v2));
    check({tag, ".focus"},    16'(bus.focus),    16'(f));
  endtask

  initial begin
    bus.dataIn       = '0;
    bus.inValid      = 1'b0;
    bus.toggleButton = 1'b0;
    bus.autoMode     = 1'b0;

    // Reset state
    #3;
    check_outs("reset", 9'h000, 9'h000, 1'b0, 1'b0, 1'b0);
    step();
    step();
    @(negedge clk);
    rst = 1'b0;
    step();
    check_outs("post_reset_idle", 9'h000, 9'h000, 1'b0, 1'b0, 1'b0);

    // Auto mode, four back-to-back words alternate starting on channel 1
    bus.autoMode = 1'b1;
    bus.inValid  = 1'b1;
    bus.dataIn   = 9'h0A1;
    step();
    check_outs("auto_w0", 9'h0A1, 9'h000, 1'b1, 1'b0, 1'b1);
    bus.dataIn = 9'h0B2;
    step();
    check_outs("auto_w1", 9'h0A1, 9'h0B2, 1'b0, 1'b1, 1'b0);
    bus.dataIn = 9'h0C3;
    step();
    check_outs("auto_w2", 9'h0C3, 9'h0B2, 1'b1, 1'b0, 1'b1);
    bus.dataIn = 9'h0D4;
    step();
    check_outs("auto_w3", 9'h0C3, 9'h0D4, 1'b0, 1'b1, 1'b0);
    bus.inValid = 1'b0;
    bus.dataIn  = 9'h1EE;
    step();
    check_outs("auto_idle", 9'h0C3, 9'h0D4, 1'b0, 1'b0, 1'b0);

    // Auto mode, gaps in inValid hold focus; button ignored
    bus.inValid      = 1'b1;
    bus.dataIn       = 9'h011;
    bus.toggleButton = 1'b1;
    step();
    check_outs("gap_e1", 9'h011, 9'h0D4, 1'b1, 1'b0, 1'b1);
    bus.inValid = 1'b0;
    bus.dataIn  = 9'h022;
    step();
    check_outs("gap_e2", 9'h011, 9'h0D4, 1'b0, 1'b0, 1'b1);
    bus.dataIn = 9'h033;
    step();
    check_outs("gap_e3", 9'h011, 9'h0D4, 1'b0, 1'b0, 1'b1);
    bus.inValid = 1'b1;
    bus.dataIn  = 9'h044;
    step();
    check_outs("gap_e4", 9'h011, 9'h044, 1'b0, 1'b1, 1'b0);
    bus.inValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("auto_btn_ignored.focus", 16'(bus.focus), 16'h0);
    end
    bus.toggleButton = 1'b0;
    for (int i = 0; i < 10; i++) step();

    // Button mode: held press flips once, exactly at edge k+7
    bus.autoMode     = 1'b0;
    bus.toggleButton = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("press_edge_k+%0d.focus", i), 16'(bus.focus), (i >= 7) ? 16'h1 : 16'h0);
    end
    bus.toggleButton = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("release_no_flip.focus", 16'(bus.focus), 16'h1);
    end
    bus.inValid = 1'b1;
    bus.dataIn  = 9'h155;
    step();
    check_outs("word_0x155", 9'h011, 9'h155, 1'b0, 1'b1, 1'b1);
    bus.inValid = 1'b0;
    step();
    check_outs("word_0x155_after", 9'h011, 9'h155, 1'b0, 1'b0, 1'b1);

    // Three-cycle glitch is rejected
    bus.toggleButton = 1'b1;
    step();
    step();
    step();
    bus.toggleButton = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("glitch.focus", 16'(bus.focus), 16'h1);
    end

    // Button mode: inValid alone never moves focus
    bus.inValid = 1'b1;
    bus.dataIn  = 9'h066;
    step();
    check_outs("btn_mode_word", 9'h011, 9'h066, 1'b0, 1'b1, 1'b1);
    bus.inValid = 1'b0;

    // Press back to FOCUS1
    bus.toggleButton = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check("back_to_focus1.focus", 16'(bus.focus), 16'h0);
    bus.toggleButton = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("back_to_focus1_hold.focus", 16'(bus.focus), 16'h0);

    // Toggle pulse coincides with a word in FOCUS1
    bus.toggleButton = 1'b1;
    for (int i = 0; i < 7; i++) step();
    check("coincide_pre.focus", 16'(bus.focus), 16'h0);
    bus.inValid = 1'b1;
    bus.dataIn  = 9'h1FF;
    step();
    check_outs("coincide", 9'h1FF, 9'h066, 1'b1, 1'b0, 1'b1);
    bus.inValid      = 1'b0;
    bus.toggleButton = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check_outs("coincide_settle", 9'h1FF, 9'h066, 1'b0, 1'b0, 1'b1);

    // Async reset mid-debounce in FOCUS2 (counter at 2 after edge k+3)
    bus.toggleButton = 1'b1;
    step();
    step();
    step();
    bus.inValid = 1'b1;
    bus.dataIn  = 9'h077;
    step();
    check_outs("pre_rst_strobe", 9'h1FF, 9'h077, 1'b0, 1'b1, 1'b1);
    bus.inValid = 1'b0;
    #3;
    rst = 1'b1;
    bus.toggleButton = 1'b0;
    #1;
    check_outs("async_rst", 9'h000, 9'h000, 1'b0, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    bus.inValid = 1'b1;
    bus.dataIn  = 9'h0AA;
    step();
    check_outs("first_after_rst", 9'h0AA, 9'h000, 1'b1, 1'b0, 1'b0);
    bus.inValid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("no_pulse_after_rst.focus", 16'(bus.focus), 16'h0);
    end
    check_outs("final", 9'h0AA, 9'h000, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/demux_sequencial.md
DEMUX_SEQUENCIAL -- requirements
Module: demux_sequencial

Interface
REQ-001 SHALL have parameter DATABUS_WIDTH, default 9, the data bus width in bits.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, the number of consecutive synchronized cycles toggleButton must hold a new level before it is accepted.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset; asynchronous, active-high.
REQ-005 SHALL have port dataIn, input, DATABUS_WIDTH bits, the shared input word.
REQ-006 SHALL have port inValid, input, 1 bit; when high, dataIn is a word to route this cycle.
REQ-007 SHALL have port toggleButton, input, 1 bit, the raw asynchronous push-button for focus selection.
REQ-008 SHALL have port autoMode, input, 1 bit: 1 = alternate per word, 0 = button-driven.
REQ-009 SHALL have port dataOut1, output, DATABUS_WIDTH bits, the registered word for channel 1.
REQ-010 SHALL have port dataOut2, output, DATABUS_WIDTH bits, the registered word for channel 2.
REQ-011 SHALL have port valid1, output, 1 bit, a one-cycle strobe marking a new dataOut1.
REQ-012 SHALL have port valid2, output, 1 bit, a one-cycle strobe marking a new dataOut2.
REQ-013 SHALL have port focus, output, 1 bit, the current state: 0 = FOCUS1, 1 = FOCUS2.

Function
REQ-014 SHALL implement a two-state FSM, FOCUS1 (0) and FOCUS2 (1); any illegal value SHALL recover to FOCUS1.
REQ-015 SHALL, on an edge with inValid=1 and focus=FOCUS1, load dataIn into dataOut1 and set valid1=1 for exactly the following cycle; dataOut2 and valid2 are unaffected.
REQ-016 SHALL, on an edge with inValid=1 and focus=FOCUS2, load dataIn into dataOut2 and set valid2=1 for exactly the following cycle; dataOut1 and valid1 are unaffected.
REQ-017 SHALL hold dataOut1 and dataOut2 unchanged between captures; each validN SHALL be 0 on any cycle not following a capture into channel N.
REQ-018 SHALL have a capture latency of 1 clock from the inValid sample to the validN/dataOutN update; valid1 and valid2 SHALL never be high together.
REQ-019 SHALL, when autoMode=1, flip focus on every edge where inValid=1, after routing that word per the pre-flip focus; toggle pulses SHALL be ignored.
REQ-020 SHALL, when autoMode=1 and inValid=0, hold focus.
REQ-021 SHALL, when autoMode=0, flip focus only on edges where the toggle pulse is high; inValid SHALL not affect focus.
REQ-022 SHALL, when autoMode=0 and inValid and the toggle pulse coincide, capture with the pre-flip focus and then flip.
REQ-023 SHALL sample autoMode every cycle with no registration; a mode change applies from the next edge.
REQ-024 SHALL pass toggleButton through a 2-flop synchronizer (sync1, sync2).
REQ-025 SHALL increment the debounce counter on each edge where sync2 differs from the debounced level.
REQ-026 SHALL, when sync2 differs and the counter equals DEBOUNCE_CYCLES-1, load sync2 into the debounced level and clear the counter.
REQ-027 SHALL clear the debounce counter on any edge where sync2 equals the debounced level.
REQ-028 SHALL generate the toggle pulse as the debounced level AND NOT its 1-cycle delayed copy, giving one pulse per accepted press; releases produce no pulse.
REQ-029 SHALL, with toggleButton rising before edge k and held, give focus flip at edge k+3+DEBOUNCE_CYCLES (k+7 at default).
REQ-030 SHALL ignore glitches shorter than DEBOUNCE_CYCLES synchronized cycles entirely.

Reset
REQ-031 SHALL, on rst=1, immediately (asynchronously) force focus=FOCUS1, dataOut1=0, dataOut2=0, valid1=0, valid2=0, sync1=0, sync2=0, debounced level=0, delayed copy=0 and counter=0.
REQ-032 SHALL, on rst asserted mid-operation, drop any pending strobe or half-counted debounce with no output effect after deassertion.
REQ-033 SHALL, on the first edge after rst deasserts, capture normally into channel 1.

Verification
REQ-034 SHALL cover: autoMode=1, inValid=1 with dataIn 0x0A1,0x0B2,0x0C3,0x0D4 on consecutive edges -> dataOut1 0x0A1 then 0x0C3, dataOut2 0x0B2 then 0x0D4, valid1/valid2 alternate each cycle starting with valid1.
REQ-035 SHALL cover: autoMode=1, inValid pattern 1,0,0,1 -> focus flips only on the two valid edges; validN is 0 during the gaps.
REQ-036 SHALL cover: autoMode=0, toggleButton held high 10 cycles -> exactly one flip to FOCUS2 at edge k+7; a following word 0x155 lands in dataOut2 only.
REQ-037 SHALL cover: autoMode=0, 3-cycle toggleButton glitch -> focus unchanged, no pulse.
REQ-038 SHALL cover: autoMode=0, toggle pulse coinciding with inValid=1, dataIn=0x1FF in FOCUS1 -> dataOut1=0x1FF, valid1=1, focus=FOCUS2 after the edge.
REQ-039 SHALL cover: rst pulsed between clock edges while in FOCUS2 with counter at 2 -> all outputs 0 immediately; next word goes to dataOut1.
